// File: rtl/lmmi2wb_pkg.sv
// Shared types and widths for the LMMI-to-Wishbone bridge.
package lmmi_wb_pkg;

  localparam int LMMI_OFFSET_W = 16;
  localparam int WB_ADR_W      = 18;
  localparam int DATA_W        = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WB_CYC  = 2'd1,
    RD_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMPL_OK      = 2'd0,
    CMPL_ERR     = 2'd1,
    CMPL_TIMEOUT = 2'd2
  } cmpl_t;

  typedef struct packed {
    state_t state;
    cmpl_t  last_cmpl;
  } dbg_t;

  function automatic logic [WB_ADR_W-1:0] byte_addr(input logic [LMMI_OFFSET_W-1:0] offset);
    return {offset, 2'b00};
  endfunction

endpackage

// File: rtl/lmmi2wb_if.sv
// LMMI target-side and Wishbone classic initiator-side signal bundles.
interface lmmi_if;
  import lmmi_wb_pkg::*;

  // A transfer is taken on a rising edge where request=1 and ready=1; request
  // while ready=0 is dropped. Read data is valid only in the rdata_valid cycle.
  logic                     request;
  logic                     wr_rdn;
  logic [LMMI_OFFSET_W-1:0] offset;
  logic [DATA_W-1:0]        wdata;
  logic                     ready;
  logic [DATA_W-1:0]        rdata;
  logic                     rdata_valid;

  modport master (output request, wr_rdn, offset, wdata,
                  input  ready, rdata, rdata_valid);
  modport slave  (input  request, wr_rdn, offset, wdata,
                  output ready, rdata, rdata_valid);
endinterface

interface wb_if;
  import lmmi_wb_pkg::*;

  logic                cyc;
  logic                stb;
  logic                we;
  logic [WB_ADR_W-1:0] adr;
  logic [DATA_W-1:0]   dat_w;
  logic [3:0]          sel;
  logic                ack;
  logic                err;
  logic [DATA_W-1:0]   dat_r;

  modport master (output cyc, stb, we, adr, dat_w, sel,
                  input  ack, err, dat_r);
  modport slave  (input  cyc, stb, we, adr, dat_w, sel,
                  output ack, err, dat_r);
endinterface

// File: rtl/lmmi2wb_timeout_ctr.sv
// Bus-cycle watchdog: counts cycles while run=1 and flags the last permitted one.
module wb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = run && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lmmi2wb.sv
// LMMI target bridging single transfers onto a Wishbone classic initiator, with bus timeout.
module lmmi2wb
  import lmmi_wb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic   clk,
  input  logic   rst_n,
  lmmi_if.slave  lmmi,
  wb_if.master   wb,
  output logic   bus_err,
  input  logic   bus_err_clr,
  output dbg_t   dbg
);

  state_t state, next_state;
  cmpl_t  last_cmpl;
  logic   accept;
  logic   expired;
  logic   done;
  logic   failed;

  assign accept = (state == IDLE) && lmmi.request;
  assign done   = (state == WB_CYC) && (wb.ack || wb.err || expired);
  // An error flag overrides a simultaneous ack; an ack in the expiry cycle still counts.
  assign failed = wb.err || (!wb.ack && expired);

  wb_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .run     (state == WB_CYC),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (lmmi.request) next_state = WB_CYC;
      WB_CYC:  if (done)         next_state = wb.we ? IDLE : RD_RESP;
      RD_RESP:                   next_state = IDLE;
      default:                   next_state = IDLE;
    endcase
  end

  always_comb begin
    lmmi.ready = 1'b0;
    wb.cyc     = 1'b0;
    wb.stb     = 1'b0;
    wb.sel     = 4'h0;
    case (state)
      IDLE:   lmmi.ready = 1'b1;
      WB_CYC: begin
        wb.cyc = 1'b1;
        wb.stb = 1'b1;
        wb.sel = 4'hF;
      end
      default: ;
    endcase
  end

  // Request fields are latched once at accept so the bus stays stable for the whole cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.adr           <= '0;
      wb.dat_w         <= '0;
      wb.we            <= 1'b0;
      lmmi.rdata       <= '0;
      lmmi.rdata_valid <= 1'b0;
      bus_err          <= 1'b0;
      last_cmpl        <= CMPL_OK;
    end else begin
      lmmi.rdata_valid <= 1'b0;
      if (accept) begin
        wb.adr   <= byte_addr(lmmi.offset);
        wb.dat_w <= lmmi.wdata;
        wb.we    <= lmmi.wr_rdn;
      end
      if (done) begin
        wb.we <= 1'b0;
        if (!wb.we) begin
          lmmi.rdata       <= failed ? ERR_RDATA : wb.dat_r;
          lmmi.rdata_valid <= 1'b1;
        end
        last_cmpl <= wb.err ? CMPL_ERR : (wb.ack ? CMPL_OK : CMPL_TIMEOUT);
      end
      if (done && failed)   bus_err <= 1'b1;
      else if (bus_err_clr) bus_err <= 1'b0;
    end
  end

  assign dbg = '{state: state, last_cmpl: last_cmpl};

endmodule

// File: tb/tb_lmmi2wb.sv
// Directed bench for lmmi2wb: reset, write, read, error, timeout, mid-cycle reset, back-to-back.
module tb_lmmi2wb;
  import lmmi_wb_pkg::*;

  localparam int          TO    = 8;
  localparam logic [31:0] ERR_D = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bus_err;
  logic bus_err_clr = 1'b0;
  dbg_t dbg;

  int tests_run = 0;
  int tests_failed = 0;

  lmmi_if lmmi ();
  wb_if   wb ();

  lmmi2wb #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR_D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lmmi        (lmmi),
    .wb          (wb),
    .bus_err     (bus_err),
    .bus_err_clr (bus_err_clr),
    .dbg         (dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- Wishbone slave model ----------------
  // slave_mode: 0 ack, 1 err, 2 never respond, 3 ack and err together
  int          slave_mode = 0;
  int          slave_wait = 0;
  int          wcnt;
  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       wcnt <= 0;
    else if (!wb.cyc) wcnt <= 0;
    else              wcnt <= wcnt + 1;
  end

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (wb.cyc && wb.stb && wb.we && wb.ack) mem[wb.adr[9:2]] <= wb.dat_w;
  end

  assign wb.ack   = wb.cyc && wb.stb && (wcnt == slave_wait) && (slave_mode == 0 || slave_mode == 3);
  assign wb.err   = wb.cyc && wb.stb && (wcnt == slave_wait) && (slave_mode == 1 || slave_mode == 3);
  assign wb.dat_r = mem[wb.adr[9:2]];

  // ---------------- bus monitor ----------------
  int          rv_count = 0;
  int          stab_errs = 0;
  logic        prev_cyc = 1'b0;
  logic [54:0] prev_bus = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cyc = 1'b0;
    end else begin
      if (lmmi.rdata_valid) rv_count++;
      if (wb.cyc !== wb.stb) stab_errs++;
      if (wb.cyc && prev_cyc && ({wb.adr, wb.we, wb.dat_w, wb.sel} !== prev_bus)) stab_errs++;
      prev_cyc = wb.cyc;
      prev_bus = {wb.adr, wb.we, wb.dat_w, wb.sel};
    end
  end

  logic [31:0] exp_q [$];

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pl_idx = idx;
    pl_val = val;
    pl_en  = 1'b1;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  // Returns one negedge after the request was presented (first cycle of the WB access).
  task automatic issue(input logic wr, input logic [15:0] off, input logic [31:0] wd);
    int n = 0;
    while (lmmi.ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests_run++; tests_failed++;
      $display("FAIL issue_ready_wait: ready=%b required 1", lmmi.ready);
    end
    lmmi.request = 1'b1;
    lmmi.wr_rdn  = wr;
    lmmi.offset  = off;
    lmmi.wdata   = wd;
    @(negedge clk);
    lmmi.request = 1'b0;
  endtask

  task automatic wait_rv(output logic [31:0] data);
    int n = 0;
    while (lmmi.rdata_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests_run++; tests_failed++;
      $display("FAIL wait_rdata_valid: rdata_valid=%b required 1", lmmi.rdata_valid);
    end
    data = lmmi.rdata;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (lmmi.ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests_run++; tests_failed++;
      $display("FAIL wait_ready: ready=%b required 1", lmmi.ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    lmmi.request = 1'b0; lmmi.wr_rdn = 1'b0; lmmi.offset = '0; lmmi.wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({lmmi.ready, lmmi.rdata_valid, wb.cyc, wb.stb, wb.we, wb.sel, bus_err} !== 10'b1_0_0_0_0_0000_0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected %b",
               {lmmi.ready, lmmi.rdata_valid, wb.cyc, wb.stb, wb.we, wb.sel, bus_err}, 10'b1_0_0_0_0_0000_0);
    end
    tests_run++;
    if ({lmmi.rdata, wb.adr, wb.dat_w} !== 82'd0) begin
      tests_failed++;
      $display("FAIL reset_data: rdata=%h adr=%h dat_w=%h expected all 0", lmmi.rdata, wb.adr, wb.dat_w);
    end
    tests_run++;
    if (dbg.state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d expected %0d", dbg.state, IDLE);
    end
  endtask

  task automatic test_write();
    logic bad = 1'b0;
    slave_mode = 0;
    slave_wait = 3;
    issue(1'b1, 16'h0012, 32'hA5A5_0001);
    tests_run++;
    if ({wb.cyc, wb.stb, wb.we, wb.sel, wb.adr, wb.dat_w, lmmi.ready} !== {3'b111, 4'hF, 18'h00048, 32'hA5A5_0001, 1'b0}) begin
      tests_failed++;
      $display("FAIL write_bus: cyc=%b stb=%b we=%b sel=%h adr=%h dat_w=%h ready=%b expected 1 1 1 f 00048 a5a50001 0",
               wb.cyc, wb.stb, wb.we, wb.sel, wb.adr, wb.dat_w, lmmi.ready);
    end
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      if (lmmi.ready !== 1'b0 || lmmi.rdata_valid !== 1'b0 || wb.cyc !== 1'b1) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL write_wait: ready/rdata_valid/cyc wrong during wait states, got bad=%b expected 0", bad);
    end
    @(negedge clk);
    tests_run++;
    if ({lmmi.ready, wb.cyc, wb.we, wb.sel, lmmi.rdata_valid} !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL write_done: ready=%b cyc=%b we=%b sel=%h rv=%b expected 1 0 0 0 0",
               lmmi.ready, wb.cyc, wb.we, wb.sel, lmmi.rdata_valid);
    end
  endtask

  task automatic test_read();
    logic [31:0] d;
    slave_mode = 0;
    slave_wait = 0;
    preload(8'd3, 32'h1234_5678);
    issue(1'b0, 16'h0003, 32'h0);
    tests_run++;
    if ({wb.cyc, wb.we, wb.adr, lmmi.rdata_valid} !== {1'b1, 1'b0, 18'h0000C, 1'b0}) begin
      tests_failed++;
      $display("FAIL read_bus: cyc=%b we=%b adr=%h rv=%b expected 1 0 0000c 0", wb.cyc, wb.we, wb.adr, lmmi.rdata_valid);
    end
    @(negedge clk);
    tests_run++;
    if ({lmmi.rdata_valid, lmmi.ready, wb.cyc, lmmi.rdata} !== {3'b100, 32'h1234_5678}) begin
      tests_failed++;
      $display("FAIL read_resp: rv=%b ready=%b cyc=%b rdata=%h expected 1 0 0 12345678",
               lmmi.rdata_valid, lmmi.ready, wb.cyc, lmmi.rdata);
    end
    @(negedge clk);
    tests_run++;
    if ({lmmi.rdata_valid, lmmi.ready, lmmi.rdata} !== {2'b01, 32'h1234_5678}) begin
      tests_failed++;
      $display("FAIL read_pulse_end: rv=%b ready=%b rdata=%h expected 0 1 12345678",
               lmmi.rdata_valid, lmmi.ready, lmmi.rdata);
    end
    issue(1'b0, 16'h0003, 32'h0);
    tests_run++;
    if (wb.cyc !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_next_accept: cyc=%b expected 1", wb.cyc);
    end
    wait_rv(d);
    @(negedge clk);
  endtask

  task automatic test_error();
    logic [31:0] d;
    slave_wait = 0;
    slave_mode = 1;
    issue(1'b0, 16'h0005, 32'h0);
    @(negedge clk);
    tests_run++;
    if ({lmmi.rdata_valid, bus_err, lmmi.rdata} !== {2'b11, 32'hDEAD_BEEF}) begin
      tests_failed++;
      $display("FAIL err_resp: rv=%b bus_err=%b rdata=%h expected 1 1 deadbeef", lmmi.rdata_valid, bus_err, lmmi.rdata);
    end
    slave_mode = 0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus_err !== 1'b1 || dbg.last_cmpl !== CMPL_ERR) begin
      tests_failed++;
      $display("FAIL err_sticky: bus_err=%b last_cmpl=%0d expected 1 %0d", bus_err, dbg.last_cmpl, CMPL_ERR);
    end
    bus_err_clr = 1'b1;
    @(negedge clk);
    bus_err_clr = 1'b0;
    tests_run++;
    if (bus_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_clear: bus_err=%b expected 0", bus_err);
    end
    slave_mode = 3;
    preload(8'd6, 32'h5555_AAAA);
    issue(1'b0, 16'h0006, 32'h0);
    wait_rv(d);
    tests_run++;
    if ({bus_err, d} !== {1'b1, 32'hDEAD_BEEF}) begin
      tests_failed++;
      $display("FAIL err_with_ack: bus_err=%b rdata=%h expected 1 deadbeef", bus_err, d);
    end
    slave_mode = 0;
    bus_err_clr = 1'b1;
    @(negedge clk);
    bus_err_clr = 1'b0;
  endtask

  task automatic test_timeout();
    logic bad = 1'b0;
    logic [31:0] d;
    slave_mode = 2;
    issue(1'b0, 16'h0007, 32'h0);
    for (int k = 2; k <= TO; k++) begin
      @(negedge clk);
      if (wb.cyc !== 1'b1 || lmmi.rdata_valid !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL timeout_hold: cyc dropped or rv early, got bad=%b expected 0", bad);
    end
    @(negedge clk);
    tests_run++;
    if ({wb.cyc, lmmi.rdata_valid, bus_err, lmmi.rdata} !== {3'b011, 32'hDEAD_BEEF} || dbg.last_cmpl !== CMPL_TIMEOUT) begin
      tests_failed++;
      $display("FAIL timeout_resp: cyc=%b rv=%b bus_err=%b rdata=%h cmpl=%0d expected 0 1 1 deadbeef %0d",
               wb.cyc, lmmi.rdata_valid, bus_err, lmmi.rdata, dbg.last_cmpl, CMPL_TIMEOUT);
    end
    @(negedge clk);
    tests_run++;
    if (lmmi.ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_ready: ready=%b expected 1", lmmi.ready);
    end
    bus_err_clr = 1'b1;
    @(negedge clk);
    bus_err_clr = 1'b0;
    slave_mode = 0;
    slave_wait = 1;
    issue(1'b1, 16'h0007, 32'h0BAD_F00D);
    wait_ready();
    issue(1'b0, 16'h0007, 32'h0);
    wait_rv(d);
    tests_run++;
    if ({bus_err, d} !== {1'b0, 32'h0BAD_F00D} || dbg.last_cmpl !== CMPL_OK) begin
      tests_failed++;
      $display("FAIL timeout_recover: bus_err=%b rdata=%h cmpl=%0d expected 0 0badf00d %0d",
               bus_err, d, dbg.last_cmpl, CMPL_OK);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic bad = 1'b0;
    slave_mode = 2;
    issue(1'b0, 16'h0009, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({wb.cyc, wb.stb, wb.we, wb.sel, lmmi.ready, lmmi.rdata_valid, bus_err} !== 10'b0_0_0_0000_1_0_0 ||
        {wb.adr, wb.dat_w, lmmi.rdata} !== 82'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_values: cyc=%b stb=%b we=%b sel=%h ready=%b rv=%b adr=%h dat_w=%h rdata=%h expected 0 0 0 0 1 0 0 0 0",
               wb.cyc, wb.stb, wb.we, wb.sel, lmmi.ready, lmmi.rdata_valid, wb.adr, wb.dat_w, lmmi.rdata);
    end
    slave_mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (lmmi.rdata_valid !== 1'b0 || lmmi.ready !== 1'b1 || wb.cyc !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL reset_mid_after: stray activity after release, got bad=%b expected 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ref_mem [0:31];
    logic [31:0] d;
    logic [31:0] e;
    logic        wr;
    logic [4:0]  off;
    logic [31:0] wd;
    int          n_reads = 0;
    int          rv0;
    int          st0;
    slave_mode = 0;
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = 32'hC0DE_0000 + 32'(i * 17);
      preload(8'(i), ref_mem[i]);
    end
    rv0 = rv_count;
    st0 = stab_errs;
    for (int i = 0; i < 100; i++) begin
      wr  = 1'($urandom_range(0, 1));
      off = 5'($urandom_range(0, 31));
      wd  = $urandom;
      slave_wait = $urandom_range(0, 5);
      if (wr) begin
        issue(1'b1, {11'd0, off}, wd);
        ref_mem[off] = wd;
        wait_ready();
      end else begin
        exp_q.push_back(ref_mem[off]);
        n_reads++;
        issue(1'b0, {11'd0, off}, 32'h0);
        wait_rv(d);
        e = exp_q.pop_front();
        tests_run++;
        if (d !== e) begin
          tests_failed++;
          $display("FAIL b2b_read[%0d] off=%0d: got %h expected %h", i, off, d, e);
        end
      end
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (rv_count - rv0 !== n_reads) begin
      tests_failed++;
      $display("FAIL b2b_rv_count: got %0d expected %0d", rv_count - rv0, n_reads);
    end
    tests_run++;
    if (stab_errs - st0 !== 0) begin
      tests_failed++;
      $display("FAIL b2b_bus_stable: got %0d violations expected 0", stab_errs - st0);
    end
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL b2b_queue_empty: got %0d entries expected 0", exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write();
    test_read();
    test_error();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
